// File: rtl/grf_write_queue.sv
// grf_write_queue: in-order GRF write-back queue with rs/rt hazard lookup.
// Optional forwarding of the youngest pending write is built when WBQ_BYPASS_EN is defined.
module grf_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rd,
    input  logic [31:0]   in_data,
    input  logic [31:0]   in_pc,
    input  logic          in_jal,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_rd,
    output logic [31:0]   out_data,
    output logic [31:0]   out_pc,
    input  logic [4:0]    q_rs,
    input  logic [4:0]    q_rt,
    output logic          rs_hit,
    output logic          rt_hit,
    output logic [31:0]   rs_fwd,
    output logic [31:0]   rt_fwd,
    output logic [AW:0]   count
);
    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, idx;
    logic [AW:0]   cnt;
    logic          push, pop;
    logic [4:0]    new_rd;
    logic [31:0]   new_data;
`ifdef WBQ_BYPASS_EN
    logic [31:0]   rs_d, rt_d;
`endif

    assign count     = cnt;
    assign in_ready  = cnt != (AW+1)'(DEPTH);
    assign out_valid = cnt != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign new_rd    = in_jal ? 5'd31 : in_rd;
    assign new_data  = (new_rd == 5'd0) ? 32'd0 : in_jal ? in_pc + 32'd4 : in_data;
    assign out_rd    = out_valid ? rd_q[rd_ptr] : 5'd0;
    assign out_data  = out_valid ? data_q[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? pc_q[rd_ptr] : 32'd0;

    // queue storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                rd_q[wr_ptr]   <= new_rd;
                data_q[wr_ptr] <= new_data;
                pc_q[wr_ptr]   <= in_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // hazard scan from oldest to youngest so the last match is the youngest pending write
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        idx    = '0;
`ifdef WBQ_BYPASS_EN
        rs_d   = '0;
        rt_d   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + AW'(k);
            if ((AW+1)'(k) < cnt && q_rs != 5'd0 && rd_q[idx] == q_rs) begin
                rs_hit = 1'b1;
`ifdef WBQ_BYPASS_EN
                rs_d   = data_q[idx];
`endif
            end
            if ((AW+1)'(k) < cnt && q_rt != 5'd0 && rd_q[idx] == q_rt) begin
                rt_hit = 1'b1;
`ifdef WBQ_BYPASS_EN
                rt_d   = data_q[idx];
`endif
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    assign rs_fwd = rs_d;
    assign rt_fwd = rt_d;
`else
    assign rs_fwd = 32'd0;
    assign rt_fwd = 32'd0;
`endif
endmodule
